bus_sram_responder: RTL and testbench

BUS_SRAM_RESPONDER -- requirements
Module: bus_sram_responder

---
 rtl/cpu_defs.sv | 27 ++
 rtl/bus_sram_responder_if.sv | 24 ++
 rtl/bus_sram_responder_array.sv | 45 ++++
 rtl/bus_sram_responder.sv | 104 ++++++++++
 tb/tb_bus_sram_responder.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/cpu_defs.sv
// Shared CPU bus definitions: word and byte-mask types, bus field widths,
// and the state encoding of the bus SRAM responder.
package cpu_defs;

   localparam int BUS_ADDR_W  = 32;
   localparam int BUS_DATA_W  = 32;
   localparam int BUS_MASK_W  = BUS_DATA_W / 8;
   localparam int EXTRA_W     = 4;
   localparam int CNT_W       = 5;

   typedef logic [BUS_DATA_W-1:0] Word_t;
   typedef logic [BUS_MASK_W-1:0] ByteMask_t;
   typedef logic [CNT_W-1:0]      count_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } sram_state_e;

   // Number of BUSY cycles that follow the accept cycle.
   function automatic count_t busy_cycles(input int unsigned latency,
                                          input logic [EXTRA_W-1:0] extra);
      return count_t'(latency) + count_t'(extra) - count_t'(1);
   endfunction

endpackage

// File: rtl/bus_sram_responder_if.sv
// Request/response signals between a bus master and the SRAM responder.
interface bus_sram_responder_if
   import cpu_defs::*;
();

   logic [BUS_ADDR_W-1:0] bus_address;
   logic                  bus_read;
   logic                  bus_write;
   ByteMask_t             bus_mask;
   Word_t                 bus_wrdata;
   Word_t                 bus_rddata;
   logic                  bus_stall;

   modport master (
      output bus_address, bus_read, bus_write, bus_mask, bus_wrdata,
      input  bus_rddata, bus_stall
   );

   modport slave (
      input  bus_address, bus_read, bus_write, bus_mask, bus_wrdata,
      output bus_rddata, bus_stall
   );

endinterface

// File: rtl/bus_sram_responder_array.sv
// Single-port, byte-writable word array with a registered read-first port.
module bus_sram_array
   import cpu_defs::*;
#(
   parameter int ADDR_W = 14
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd_en,
   input  logic              wr_en,
   input  ByteMask_t         wr_mask,
   input  logic [ADDR_W-1:0] addr,
   input  Word_t             wr_data,
   output Word_t             rd_data
);

   Word_t mem [0:(1 << ADDR_W)-1];
   Word_t rdata_q;
   Word_t rdata_d;

   always_comb begin
      rdata_d = rdata_q;
      if (rd_en) rdata_d = mem[addr];
   end

   // NOTE: the array itself has no reset; only the read register does, so
   // contents survive a reset and the storage maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < BUS_MASK_W; b++) begin
            if (wr_mask[b]) mem[addr][8*b +: 8] <= wr_data[8*b +: 8];
         end
      end
   end

   // NOTE: state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rdata_q <= '0;
      else     rdata_q <= rdata_d;
   end

   assign rd_data = rdata_q;

endmodule

// File: rtl/bus_sram_responder.sv
// Bus-facing SRAM responder: accepts one request, stalls for a programmable
// number of cycles, performs the array access, then answers for one cycle.
module bus_sram_responder
   import cpu_defs::*;
#(
   parameter int ADDR_W  = 14,
   parameter int LATENCY = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [EXTRA_W-1:0] extra_wait,
   bus_sram_responder_if.slave bus
);

   sram_state_e       state_q, state_d;
   count_t            cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              rd_q, rd_d;
   logic              wr_q, wr_d;
   ByteMask_t         mask_q, mask_d;
   Word_t             wdata_q, wdata_d;

   logic req;
   logic accept;
   logic access;
   logic unused_addr_bits;

   assign unused_addr_bits = ^{bus.bus_address[BUS_ADDR_W-1:ADDR_W+2], bus.bus_address[1:0]};

   // Requests are invisible while reset is held.
   assign req    = (bus.bus_read | bus.bus_write) & ~rst;
   assign accept = (state_q == ST_IDLE) & req;

   // NOTE: every always_comb output gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      mask_d  = mask_q;
      wdata_d = wdata_q;
      unique case (state_q)
         ST_IDLE: begin
            if (req) begin
               addr_d  = bus.bus_address[ADDR_W+1:2];
               rd_d    = bus.bus_read;
               wr_d    = bus.bus_write;
               mask_d  = bus.bus_mask;
               wdata_d = bus.bus_wrdata;
               cnt_d   = busy_cycles(LATENCY, extra_wait);
               state_d = (cnt_d == '0) ? ST_RESP : ST_BUSY;
            end
         end
         ST_BUSY: begin
            cnt_d = (cnt_q == '0) ? '0 : cnt_q - count_t'(1);
            if (cnt_q <= count_t'(1)) state_d = ST_RESP;
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // The array is driven from the next-state values so a zero-wait access
   // straight from IDLE uses the request as presented.
   assign access = (state_d == ST_RESP) & (state_q != ST_RESP);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         mask_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         mask_q  <= mask_d;
         wdata_q <= wdata_d;
      end
   end

   bus_sram_array #(
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk     (clk),
      .rst     (rst),
      .rd_en   (access & rd_d),
      .wr_en   (access & wr_d),
      .wr_mask (mask_d),
      .addr    (addr_d),
      .wr_data (wdata_d),
      .rd_data (bus.bus_rddata)
   );

   assign bus.bus_stall = accept | (state_q == ST_BUSY);

endmodule

// File: tb/tb_bus_sram_responder.sv
// Directed self-checking bench for bus_sram_responder (default parameters).
module tb_bus_sram_responder;
   import cpu_defs::*;

   localparam int ADDR_W  = 14;
   localparam int LATENCY = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] extra_wait;
   int         cyc = 0;
   int         n_checks = 0;
   int         n_pass = 0;

   bus_sram_responder_if bus ();

   bus_sram_responder #(
      .ADDR_W  (ADDR_W),
      .LATENCY (LATENCY)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .extra_wait (extra_wait),
      .bus        (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   task automatic drive(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [3:0] m, input logic [31:0] d, input logic [3:0] ew);
      bus.bus_read    = rd;
      bus.bus_write   = wr;
      bus.bus_address = a;
      bus.bus_mask    = m;
      bus.bus_wrdata  = d;
      extra_wait      = ew;
   endtask

   // Presents a request at a negedge and counts stalled cycles up to the
   // RESP cycle; the request stays asserted through RESP.
   task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [3:0] m, input logic [31:0] d, input logic [3:0] ew,
                         output int stalls, output int acc_cyc, output int resp_cyc,
                         output logic [31:0] rdat);
      @(negedge clk);
      drive(rd, wr, a, m, d, ew);
      acc_cyc  = cyc;
      resp_cyc = -1;
      stalls   = 0;
      for (int c = 0; c < 40; c++) begin
         #1;
         if (bus.bus_stall) begin
            stalls++;
            @(negedge clk);
         end else begin
            resp_cyc = cyc;
            break;
         end
      end
      rdat = bus.bus_rddata;
   endtask

   task automatic release_bus();
      @(negedge clk);
      drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 4'h0);
   endtask

   task automatic wr_word(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] m, input logic [3:0] ew);
      int s, ac, rc;
      logic [31:0] r;
      access(1'b0, 1'b1, a, m, d, ew, s, ac, rc, r);
      check({tag, "_stalls"}, 32'(s), 32'(LATENCY + int'(ew)));
      release_bus();
   endtask

   task automatic rd_word(input string tag, input logic [31:0] a, input logic [31:0] exp);
      int s, ac, rc;
      logic [31:0] r;
      access(1'b1, 1'b0, a, 4'h0, 32'h0, 4'h0, s, ac, rc, r);
      check({tag, "_data"}, r, exp);
      check({tag, "_stalls"}, 32'(s), 32'(LATENCY));
      release_bus();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0, a0, r0, s1, a1, r1;
      logic [31:0] d0, d1;

      rst = 1'b1;
      drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 4'h0);
      repeat (2) @(negedge clk);
      #1;
      check("reset_stall", {31'b0, bus.bus_stall}, 32'h0);
      check("reset_rddata", bus.bus_rddata, 32'h0);
      drive(1'b1, 1'b0, 32'h100, 4'h0, 32'h0, 4'h0);
      #1;
      check("req_in_reset_stall", {31'b0, bus.bus_stall}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 4'h0);

      // Full write then read-back.
      wr_word("wr100", 32'h100, 32'h1234_5678, 4'hF, 4'd0);
      check("rddata_unchanged_by_write", bus.bus_rddata, 32'h0);
      rd_word("rd100", 32'h100, 32'h1234_5678);

      // Partial write of bytes 0 and 2.
      wr_word("wr100_m5", 32'h100, 32'hAABB_CCDD, 4'h5, 4'd0);
      check("rddata_hold_after_write", bus.bus_rddata, 32'h1234_5678);
      rd_word("rd100_m5", 32'h100, 32'h12BB_56DD);

      // Mask 0 write: normal timing, memory untouched.
      wr_word("wr100_m0", 32'h100, 32'hFFFF_FFFF, 4'h0, 4'd0);
      rd_word("rd100_m0", 32'h100, 32'h12BB_56DD);

      // Back-to-back reads with extra wait.
      wr_word("wr0", 32'h0, 32'hA0A0_A0A0, 4'hF, 4'd0);
      wr_word("wr4", 32'h4, 32'h0B0B_0B0B, 4'hF, 4'd0);
      access(1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 4'd3, s0, a0, r0, d0);
      access(1'b1, 1'b0, 32'h4, 4'h0, 32'h0, 4'd3, s1, a1, r1, d1);
      release_bus();
      check("b2b_first_data", d0, 32'hA0A0_A0A0);
      check("b2b_first_stalls", 32'(s0), 32'(LATENCY + 3));
      check("b2b_second_data", d1, 32'h0B0B_0B0B);
      check("b2b_second_stalls", 32'(s1), 32'(LATENCY + 3));
      check("b2b_accept_after_resp", 32'(a1), 32'(r0 + 1));

      // Simultaneous read and write behaves as a read-first write.
      wr_word("wr8", 32'h8, 32'h1, 4'hF, 4'd0);
      access(1'b1, 1'b1, 32'h8, 4'hF, 32'h2, 4'd0, s0, a0, r0, d0);
      release_bus();
      check("rw8_old_data", d0, 32'h1);
      check("rw8_stalls", 32'(s0), 32'(LATENCY));
      rd_word("rd8", 32'h8, 32'h2);

      // Reset in the middle of a write discards it.
      wr_word("wrC", 32'hC, 32'h0, 4'hF, 4'd0);
      @(negedge clk);
      drive(1'b0, 1'b1, 32'hC, 4'hF, 32'hFFFF_FFFF, 4'd3);
      @(negedge clk);
      @(negedge clk);
      #1;
      check("busy_before_reset", {31'b0, bus.bus_stall}, 32'h1);
      rst = 1'b1;
      #1;
      check("midreset_stall", {31'b0, bus.bus_stall}, 32'h0);
      check("midreset_rddata", bus.bus_rddata, 32'h0);
      @(negedge clk);
      #1;
      check("midreset_req_ignored", {31'b0, bus.bus_stall}, 32'h0);
      rst = 1'b0;
      drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 4'h0);
      rd_word("rdC_after_reset", 32'hC, 32'h0);

      // Address wrap and byte-offset bits are ignored.
      wr_word("wr_wrap", 32'h4 + (32'h1 << (ADDR_W + 2)), 32'h55, 4'hF, 4'd0);
      rd_word("rd_wrap", 32'h4, 32'h55);
      rd_word("rd_offset", 32'h7, 32'h55);

      // Maximum extra wait.
      wr_word("wr20_ew15", 32'h20, 32'hCAFE_F00D, 4'hF, 4'd15);
      rd_word("rd20", 32'h20, 32'hCAFE_F00D);

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
